// File: rtl/gcd_job_ctrl.sv
// Job front-end for one gcd_processor: accepts operand pairs, starts the engine, returns result or timeout.
// Latency: start pulses 1 cycle after job acceptance; zero-operand jobs bypass the engine and are ready 1 cycle after acceptance.
// Backpressure: one job in flight; job_ready stays low until the result is taken on res_valid/res_ready.
module gcd_job_ctrl #(
    parameter int BIT_LEN        = 32,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 16
) (
    input  logic               clk_i,
    input  logic               reset,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic [BIT_LEN-1:0] job_num_0,
    input  logic [BIT_LEN-1:0] job_num_1,
    output logic               gcd_start,
    output logic [BIT_LEN-1:0] gcd_num_0,
    output logic [BIT_LEN-1:0] gcd_num_1,
    input  logic               gcd_busy,
    input  logic               gcd_done,
    input  logic [BIT_LEN-1:0] gcd_op,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [BIT_LEN-1:0] res_gcd,
    output logic               res_timeout,
    output logic               res_bypass,
    output logic [CNT_W-1:0]   jobs_done
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } state_t;

    state_t             state;
    logic [TMR_W-1:0]   timer;
    logic               job_acc;
    logic               zero_op;

    // Gating with reset drops job_ready in the very cycle reset asserts.
    assign job_ready = (state == IDLE) & ~gcd_busy & ~reset;
    assign job_acc   = job_valid & job_ready;
    assign zero_op   = (job_num_0 == '0) | (job_num_1 == '0);

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            gcd_start   <= 1'b0;
            gcd_num_0   <= '0;
            gcd_num_1   <= '0;
            res_valid   <= 1'b0;
            res_gcd     <= '0;
            res_timeout <= 1'b0;
            res_bypass  <= 1'b0;
            jobs_done   <= '0;
        end else begin
            gcd_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (job_acc) begin
                        gcd_num_0 <= job_num_0;
                        gcd_num_1 <= job_num_1;
                        if (zero_op) begin
                            // gcd(0,x)=x and gcd(0,0)=0 both reduce to an OR.
                            res_gcd     <= job_num_0 | job_num_1;
                            res_bypass  <= 1'b1;
                            res_timeout <= 1'b0;
                            res_valid   <= 1'b1;
                            state       <= HOLD;
                        end else begin
                            gcd_start <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (timer != TMR_MAX) begin
                        timer <= timer + TMR_W'(1);
                    end
                    // done takes priority over a watchdog expiry in the same cycle
                    if (gcd_done) begin
                        res_gcd     <= gcd_op;
                        res_timeout <= 1'b0;
                        res_bypass  <= 1'b0;
                        res_valid   <= 1'b1;
                        state       <= HOLD;
                    end else if (timer == TMR_LAST) begin
                        res_gcd     <= '0;
                        res_timeout <= 1'b1;
                        res_bypass  <= 1'b0;
                        res_valid   <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        jobs_done <= jobs_done + CNT_W'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
